// File: rtl/fb_rect_writer.sv
// Rectangle-fill writer for the 640x480 12-bit frame buffer.
// Accepts one fill command at a time and streams clipped pixel writes in raster order.
module fb_rect_writer #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [11:0]       cmd_rgb,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned XSW = XW + 1;
    localparam int unsigned YSW = YW + 1;
    localparam int unsigned CW  = 12;

    localparam logic [XSW-1:0]    H_LIM     = XSW'(H_RES);
    localparam logic [YSW-1:0]    V_LIM     = YSW'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [XW-1:0]       r_x0;
    logic [XW-1:0]       r_cur_x;
    logic [YW-1:0]       r_cur_y;
    logic [XW-1:0]       r_x_last;
    logic [YW-1:0]       r_y_last;
    logic [ADDR_W-1:0]   r_row_base;
    logic [CW-1:0]       r_rgb;

    logic [XSW-1:0]      w_x_sum;
    logic [YSW-1:0]      w_y_sum;
    logic [XSW-1:0]      w_x_end;
    logic [YSW-1:0]      w_y_end;
    logic [XW-1:0]       w_x_last;
    logic [YW-1:0]       w_y_last;
    logic [ADDR_W-1:0]   w_row_base_init;
    logic                w_null;
    logic                w_accept;
    logic                w_at_x_last;
    logic                w_at_y_last;

    // Clipped rectangle bounds and null detection, evaluated on the incoming command.
    always_comb begin
        w_x_sum         = XSW'(cmd_x) + XSW'(cmd_w);
        w_y_sum         = YSW'(cmd_y) + YSW'(cmd_h);
        w_x_end         = (w_x_sum > H_LIM) ? H_LIM : w_x_sum;
        w_y_end         = (w_y_sum > V_LIM) ? V_LIM : w_y_sum;
        w_x_last        = XW'(w_x_end - XSW'(1));
        w_y_last        = YW'(w_y_end - YSW'(1));
        w_row_base_init = ADDR_W'(cmd_y) * ROW_PITCH;
        w_null          = (cmd_w == '0) || (cmd_h == '0)
                       || (XSW'(cmd_x) >= H_LIM) || (YSW'(cmd_y) >= V_LIM);
    end

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
    assign w_at_x_last = (r_cur_x == r_x_last);
    assign w_at_y_last = (r_cur_y == r_y_last);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/strobe decode; wr_en follows wr_stall within the cycle.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        wr_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = w_null ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                busy  = 1'b1;
                wr_en = !wr_stall;
                if (!wr_stall && w_at_x_last && w_at_y_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch at accept, then raster walk; row base advances by addition only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x0       <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_x_last   <= '0;
            r_y_last   <= '0;
            r_row_base <= '0;
            r_rgb      <= '0;
        end else if (w_accept) begin
            r_x0       <= cmd_x;
            r_cur_x    <= cmd_x;
            r_cur_y    <= cmd_y;
            r_x_last   <= w_x_last;
            r_y_last   <= w_y_last;
            r_row_base <= w_row_base_init;
            r_rgb      <= cmd_rgb;
        end else if ((r_state == ST_DRAW) && !wr_stall) begin
            if (w_at_x_last) begin
                if (!w_at_y_last) begin
                    r_cur_x    <= r_x0;
                    r_cur_y    <= r_cur_y + YW'(1);
                    r_row_base <= r_row_base + ROW_PITCH;
                end
            end else begin
                r_cur_x <= r_cur_x + XW'(1);
            end
        end
    end

    assign wr_addr = r_row_base + ADDR_W'(r_cur_x);
    assign wr_data = r_rgb;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: directed corner cases plus random fills against a raster model.
module tb_fb_rect_writer;

    localparam int unsigned H  = 640;
    localparam int unsigned V  = 480;
    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [9:0]    cmd_x;
    logic [8:0]    cmd_y;
    logic [9:0]    cmd_w;
    logic [8:0]    cmd_h;
    logic [11:0]   cmd_rgb;
    logic          wr_stall;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    fb_rect_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_rgb   (cmd_rgb),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write addresses: every visible pixel of the rectangle, row by row.
    function automatic void build_exp(input int x, input int y, input int w, input int h);
        int xe;
        int ye;
        exp_q.delete();
        xe = (x + w > int'(H)) ? int'(H) : x + w;
        ye = (y + h > int'(V)) ? int'(V) : y + h;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back(r * int'(H) + c);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(1));
        chk({tag, "_wren"},  32'(wr_en),     32'(0));
        chk({tag, "_addr"},  32'(wr_addr),   32'(0));
        chk({tag, "_data"},  32'(wr_data),   32'(0));
        chk({tag, "_busy"},  32'(busy),      32'(0));
        chk({tag, "_done"},  32'(done),      32'(0));
    endtask

    // Issue one command from an IDLE cycle (entered at a posedge) and follow it to done.
    // stall_mode: 0 none, 1 random, 2 stall on 2nd and 3rd DRAW cycles.
    // abort_at >= 0 pulls rstn low in that post-accept cycle.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [11:0] rgb, input int stall_mode, input int abort_at,
                           input bit b2b, input int nx, input int ny, input int nw,
                           input int nh, input logic [11:0] nrgb);
        int  n;
        int  idx;
        bit  finished;
        logic st;
        build_exp(x, y, w, h);
        n        = exp_q.size();
        idx      = 0;
        finished = 1'b0;
        #1;
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_rgb   = rgb;
        cmd_valid = 1'b1;
        #1;
        chk("idle_ready", 32'(cmd_ready), 32'(1));
        chk("idle_busy",  32'(busy),      32'(0));
        chk("idle_done",  32'(done),      32'(0));
        chk("idle_wren",  32'(wr_en),     32'(0));
        @(posedge clk);
        for (int cyc = 0; cyc < 4 * n + 20 && !finished; cyc++) begin
            #1;
            if (b2b) begin
                cmd_valid = 1'b1;
                cmd_x     = 10'(nx);
                cmd_y     = 9'(ny);
                cmd_w     = 10'(nw);
                cmd_h     = 9'(nh);
                cmd_rgb   = nrgb;
            end else begin
                cmd_valid = 1'b0;
                cmd_x     = 10'($urandom);
                cmd_y     = 9'($urandom);
                cmd_w     = 10'($urandom);
                cmd_h     = 9'($urandom);
                cmd_rgb   = 12'($urandom);
            end
            if (idx < n) begin
                case (stall_mode)
                    1:       st = ($urandom_range(0, 3) == 0) && (cyc < 2 * n);
                    2:       st = (cyc == 1) || (cyc == 2);
                    default: st = 1'b0;
                endcase
            end else begin
                st = 1'($urandom_range(0, 1));
            end
            wr_stall = st;
            if (cyc == abort_at) rstn = 1'b0;
            #1;
            if (cyc == abort_at) begin
                chk_reset_vals("abort");
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("abort_hold_done", 32'(done),  32'(0));
                    chk("abort_hold_wren", 32'(wr_en), 32'(0));
                end
                rstn = 1'b1;
                @(posedge clk);
                finished = 1'b1;
            end else if (idx < n) begin
                chk("draw_busy",  32'(busy),          32'(1));
                chk("draw_ready", 32'(cmd_ready),     32'(0));
                chk("draw_done",  32'(done),          32'(0));
                chk("draw_wren",  32'(wr_en),         32'(!st));
                chk("draw_addr",  32'(wr_addr),       32'(exp_q[idx]));
                chk("draw_data",  32'(wr_data),       32'(rgb));
                if (!st) idx++;
                @(posedge clk);
            end else begin
                chk("done_pulse", 32'(done),      32'(1));
                chk("done_busy",  32'(busy),      32'(1));
                chk("done_ready", 32'(cmd_ready), 32'(0));
                chk("done_wren",  32'(wr_en),     32'(0));
                finished = 1'b1;
                @(posedge clk);
            end
        end
        chk("fill_bounded", 32'(finished), 32'(1));
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_rgb   = '0;
        wr_stall  = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);

        // Basic 3x2 fill.
        run_cmd(10, 20, 3, 2, 12'hF00, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Bottom-right corner clip.
        run_cmd(638, 479, 5, 4, 12'h0F0, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Null commands.
        run_cmd(5, 5, 0, 3, 12'h111, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        run_cmd(5, 5, 3, 0, 12'h222, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        run_cmd(640, 5, 3, 3, 12'h333, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        run_cmd(0, 480, 2, 2, 12'h444, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Directed stall on 2nd and 3rd DRAW cycles.
        run_cmd(0, 0, 4, 1, 12'h00F, 2, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Back-to-back with cmd_valid held high.
        run_cmd(100, 50, 4, 3, 12'hABC, 1, -1, 1'b1, 200, 60, 5, 2, 12'h123);
        run_cmd(200, 60, 5, 2, 12'h123, 1, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Right-edge clip spanning rows.
        run_cmd(636, 10, 9, 3, 12'h5A5, 1, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        // Reset mid-fill, then a fresh command.
        run_cmd(300, 200, 100, 100, 12'h555, 0, 50, 1'b0, 0, 0, 0, 0, 12'h000);
        run_cmd(1, 1, 2, 2, 12'h0FF, 0, -1, 1'b0, 0, 0, 0, 0, 12'h000);

        // Random fills, including ones that touch or cross the edges.
        repeat (30) begin
            int rx;
            int ry;
            int rw;
            int rh;
            rx = int'($urandom_range(0, 660));
            ry = int'($urandom_range(0, 495));
            rw = int'($urandom_range(0, 14));
            rh = int'($urandom_range(0, 9));
            run_cmd(rx, ry, rw, rh, 12'($urandom), 1, -1, 1'b0, 0, 0, 0, 0, 12'h000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
